// File: rtl/sym_decision_stats_pkg.sv
// Shared constants and helpers for the 4-ASK decision/statistics stage.
package sym_stats_pkg;

  localparam int W_SAMP = 18;   // 1s17 sample width
  localparam int W_FRAC = 17;   // magnitude bits of a 1s17 sample
  localparam int W_SQ   = 36;   // squared-error width, unsigned 2s34

  localparam logic [1:0] SL_M3 = 2'b00;
  localparam logic [1:0] SL_M1 = 2'b01;
  localparam logic [1:0] SL_P1 = 2'b10;
  localparam logic [1:0] SL_P3 = 2'b11;

  // Symmetric clamp so the error never takes the lone -1.0 code.
  function automatic logic signed [W_SAMP-1:0] sat18(input logic signed [W_SAMP:0] v);
    if (v > 19'sd131071) begin
      return 18'sd131071;
    end else if (v < -19'sd131071) begin
      return -18'sd131071;
    end else begin
      return v[W_SAMP-1:0];
    end
  endfunction

endpackage

// File: rtl/sym_decision_stats_if.sv
// Sample stream in, decisions and block statistics out.
interface sym_decision_stats_if;
  import sym_stats_pkg::*;

  logic                     sam_clk_en;
  logic                     sym_clk_en;
  logic signed [W_SAMP-1:0] mf_in;
  logic [1:0]               phase_sel;
  logic                     clr;

  logic signed [W_SAMP-1:0] dec_var;
  logic [1:0]               slice;
  logic signed [W_SAMP-1:0] error;
  logic signed [W_SAMP-1:0] ref_lvl;
  logic signed [W_SAMP-1:0] err_avg;
  logic [W_SQ-1:0]          err_sq_avg;
  logic                     done;

  modport master (
    output sam_clk_en, sym_clk_en, mf_in, phase_sel, clr,
    input  dec_var, slice, error, ref_lvl, err_avg, err_sq_avg, done
  );

  modport slave (
    input  sam_clk_en, sym_clk_en, mf_in, phase_sel, clr,
    output dec_var, slice, error, ref_lvl, err_avg, err_sq_avg, done
  );

endinterface

// File: rtl/sym_decision_stats_slice.sv
// Combinational 4-ASK slicer: decision variable and reference level R
// give the slice code and the ideal level for that code (+-R/2, +-3R/2).
module ask4_slice
  import sym_stats_pkg::*;
(
  input  logic signed [W_SAMP-1:0] dec_var,
  input  logic signed [W_SAMP-1:0] ref_lvl,
  output logic [1:0]               code,
  output logic signed [W_SAMP:0]   mapped
);

  logic signed [W_SAMP:0] dx;
  logic signed [W_SAMP:0] rx;
  logic signed [W_SAMP:0] half;
  logic signed [W_SAMP:0] outer;

  assign dx    = {dec_var[W_SAMP-1], dec_var};
  assign rx    = {ref_lvl[W_SAMP-1], ref_lvl};
  assign half  = rx >>> 1;
  assign outer = rx + half;

  // Threshold compare against 0 and +-R, picking the matching level.
  always_comb begin
    code   = SL_M3;
    mapped = -outer;
    if (dx >= rx) begin
      code   = SL_P3;
      mapped = outer;
    end else if (dx >= 19'sd0) begin
      code   = SL_P1;
      mapped = half;
    end else if (dx >= -rx) begin
      code   = SL_M1;
      mapped = -half;
    end
  end

endmodule

// File: rtl/sym_decision_stats.sv
// Symbol phase pick, slicing, and per-block magnitude/error statistics.
// Three-stage pipeline: pick (v1) -> slice/error (v2) -> accumulate.
module sym_decision_stats
  import sym_stats_pkg::*;
#(
  parameter int                       ACC_LOG2 = 10,
  parameter logic signed [W_SAMP-1:0] REF_INIT = 18'sd32768
) (
  input logic                 sys_clk,
  input logic                 reset,
  sym_decision_stats_if.slave bus
);

  localparam int MW = W_FRAC + ACC_LOG2;
  localparam int EW = W_SAMP + ACC_LOG2;
  localparam int SW = W_SQ + ACC_LOG2;

  logic signed [W_SAMP-1:0] d [4];

  logic signed [W_SAMP-1:0] dec_var_q;
  logic [1:0]               slice_q;
  logic signed [W_SAMP-1:0] error_q;
  logic signed [W_SAMP-1:0] ref_lvl_q;
  logic signed [W_SAMP-1:0] err_avg_q;
  logic [W_SQ-1:0]          err_sq_avg_q;
  logic                     done_q;
  logic                     v1;
  logic                     v2;

  logic [ACC_LOG2-1:0]      sym_cnt;
  logic [MW-1:0]            mag_acc;
  logic [MW-1:0]            mag_next;
  logic signed [EW-1:0]     err_acc;
  logic signed [EW-1:0]     err_next;
  logic [SW-1:0]            sq_acc;
  logic [SW-1:0]            sq_next;

  logic [1:0]               sl_code;
  logic signed [W_SAMP:0]   mapped;
  logic signed [W_SAMP:0]   dec_wide;
  logic signed [W_SAMP:0]   err_wide;
  logic signed [W_SAMP-1:0] err_sat;
  logic [W_FRAC-1:0]        mag_term;
  logic signed [W_SQ-1:0]   err_ext;
  logic signed [W_SQ-1:0]   sq_term;

  ask4_slice u_slice (
    .dec_var (dec_var_q),
    .ref_lvl (ref_lvl_q),
    .code    (sl_code),
    .mapped  (mapped)
  );

  assign dec_wide = {dec_var_q[W_SAMP-1], dec_var_q};
  assign err_wide = dec_wide - mapped;
  assign err_sat  = sat18(err_wide);

  // Magnitude kept to 17 bits; a full-scale negative input folds to zero.
  assign mag_term = dec_var_q[W_SAMP-1] ? W_FRAC'(-dec_var_q) : W_FRAC'(dec_var_q);
  assign err_ext  = {{(W_SQ-W_SAMP){error_q[W_SAMP-1]}}, error_q};
  assign sq_term  = err_ext * err_ext;

  assign mag_next = mag_acc + MW'(mag_term);
  assign err_next = err_acc + $signed({{ACC_LOG2{error_q[W_SAMP-1]}}, error_q});
  assign sq_next  = sq_acc + SW'($unsigned(sq_term));

  // Four-tap sample delay line, advanced on every sample strobe.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) d[k] <= '0;
    end else if (bus.sam_clk_en) begin
      d[0] <= bus.mf_in;
      for (int k = 1; k < 4; k++) d[k] <= d[k-1];
    end
  end

  // Phase pick on the symbol strobe, then slice and error one cycle later.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dec_var_q <= '0;
      slice_q   <= SL_M3;
      error_q   <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
    end else begin
      v1 <= bus.sym_clk_en & ~bus.clr;
      v2 <= v1 & ~bus.clr;
      if (bus.sym_clk_en) dec_var_q <= d[bus.phase_sel];
      if (v1) begin
        slice_q <= sl_code;
        error_q <= err_sat;
      end
    end
  end

  // Block accumulation; the final symbol is folded into the latched averages.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sym_cnt      <= '0;
      mag_acc      <= '0;
      err_acc      <= '0;
      sq_acc       <= '0;
      ref_lvl_q    <= REF_INIT;
      err_avg_q    <= '0;
      err_sq_avg_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clr) begin
        sym_cnt <= '0;
        mag_acc <= '0;
        err_acc <= '0;
        sq_acc  <= '0;
      end else if (v2) begin
        if (sym_cnt == '1) begin
          ref_lvl_q    <= {1'b0, mag_next[MW-1:ACC_LOG2]};
          err_avg_q    <= err_next[EW-1:ACC_LOG2];
          err_sq_avg_q <= sq_next[SW-1:ACC_LOG2];
          done_q       <= 1'b1;
          sym_cnt      <= '0;
          mag_acc      <= '0;
          err_acc      <= '0;
          sq_acc       <= '0;
        end else begin
          sym_cnt <= sym_cnt + ACC_LOG2'(1);
          mag_acc <= mag_next;
          err_acc <= err_next;
          sq_acc  <= sq_next;
        end
      end
    end
  end

  assign bus.dec_var    = dec_var_q;
  assign bus.slice      = slice_q;
  assign bus.error      = error_q;
  assign bus.ref_lvl    = ref_lvl_q;
  assign bus.err_avg    = err_avg_q;
  assign bus.err_sq_avg = err_sq_avg_q;
  assign bus.done       = done_q;

endmodule
